regfile_sb: RTL and testbench

- Parametrised successor to the CPU's 32x32 register file.
- Width and depth are configurable. Register 0 is hardwired to zero.
- Has two asynchronous read ports, one synchronous write port and a debug tap for the seven-segment display.
- Adds a per-register busy scoreboard with an issue-time stall signal, so the pipeline can detect RAW hazards on in-flight writebacks.
- Sits between decode (issue) and writeback. Drives the rs/rt operand muxes and the data-memory store path.

---
 rtl/regfile_sb.sv | 122 ++++++++++++
 tb/tb_regfile_sb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register busy scoreboard.
// Two combinational read ports, one synchronous write port and a debug tap.
// Register 0 always reads zero and can never be marked busy.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a same-cycle
// write is forwarded to a read port that addresses the same register.
module regfile_sb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int DBG_IDX = 17,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [DW-1:0]    rdata_a,
  output logic             rbusy_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [DW-1:0]    rdata_b,
  output logic             rbusy_b,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  output logic             iss_stall,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [DW-1:0]    dbg_data
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    regs_reg [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [CNT_W-1:0] busy_cnt_reg;
  logic [CNT_W-1:0] busy_cnt_next;

  logic wr_en;
  logic set_en;
  logic clr_en;
  logic cnt_inc;
  logic cnt_dec;

  // A real write needs a nonzero target; writes to r0 vanish.
  assign wr_en = we & (waddr != '0);

  // A pending issue to a busy register is refused unless the same cycle
  // retires that register's outstanding writeback.
  assign iss_stall = iss_valid & (iss_addr != '0) & busy_reg[iss_addr]
                   & ~(we & (waddr == iss_addr));

  assign set_en = iss_valid & ~iss_stall & (iss_addr != '0);
  assign clr_en = wr_en & busy_reg[waddr];

  // Busy next-state per register; set has priority over a same-cycle clear.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_busy
      assign busy_next[gi] = (set_en & (iss_addr == AW'(gi)))
                           | (busy_reg[gi] & ~(we & (waddr == AW'(gi))));
    end
  endgenerate

  // Count tracks busy[] incrementally: at most one bit rises and one falls.
  // A set onto an already-busy register only happens together with its own
  // clear, so it nets to zero; likewise a clear cancelled by a same-address set.
  assign cnt_inc = set_en & ~busy_reg[iss_addr];
  assign cnt_dec = clr_en & ~(set_en & (iss_addr == waddr));
  assign busy_cnt_next = busy_cnt_reg + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

  // Register array: cleared by reset, written on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en) begin
      regs_reg[waddr] <= wdata;
    end
  end

  // Scoreboard state and its population count update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign busy_cnt = busy_cnt_reg;
  assign dbg_data = regs_reg[DBG_IDX];

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write to a matching read port; its busy bit reads clear.
  always_comb begin
    rdata_a = regs_reg[raddr_a];
    rbusy_a = busy_reg[raddr_a];
    rdata_b = regs_reg[raddr_b];
    rbusy_b = busy_reg[raddr_b];
    if (wr_en && (waddr == raddr_a)) begin
      rdata_a = wdata;
      rbusy_a = 1'b0;
    end
    if (wr_en && (waddr == raddr_b)) begin
      rdata_b = wdata;
      rbusy_b = 1'b0;
    end
  end
`else
  // Reads see registered contents only; r0 is never written so it reads 0.
  always_comb begin
    rdata_a = regs_reg[raddr_a];
    rbusy_a = busy_reg[raddr_a];
    rdata_b = regs_reg[raddr_b];
    rbusy_b = busy_reg[raddr_b];
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic against an
// array-based reference model of the register file and scoreboard.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int DBG   = 17;
  localparam int CNT_W = 6;

  logic             clk;
  logic             rst;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [AW-1:0]    raddr_a;
  logic [DW-1:0]    rdata_a;
  logic             rbusy_a;
  logic [AW-1:0]    raddr_b;
  logic [DW-1:0]    rdata_b;
  logic             rbusy_b;
  logic             iss_valid;
  logic [AW-1:0]    iss_addr;
  logic             iss_stall;
  logic [CNT_W-1:0] busy_cnt;
  logic [DW-1:0]    dbg_data;

  int n_cmp;
  int n_err;

  // reference model
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_sb #(.DW(DW), .AW(AW), .DBG_IDX(DBG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .rbusy_a(rbusy_a),
    .raddr_b(raddr_b), .rdata_b(rdata_b), .rbusy_b(rbusy_b),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .busy_cnt(busy_cnt), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic model_stall();
    return iss_valid && iss_addr != 0 && m_busy[iss_addr] && !(we && waddr == iss_addr);
  endfunction

  function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
    if (BYPASS && we && waddr != 0 && waddr == a) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic model_rbusy(input logic [AW-1:0] a);
    if (BYPASS && we && waddr != 0 && waddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Advance one clock: apply the current inputs to the model at the edge,
  // then return at the following falling edge ready for new stimulus.
  task automatic tick();
    logic st;
    st = model_stall();
    @(posedge clk);
    if (we) begin
      if (waddr != 0) m_regs[waddr] = wdata;
      m_busy[waddr] = 1'b0;
    end
    if (iss_valid && !st && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; iss_valid = 0; waddr = '0; wdata = '0; iss_addr = '0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); raddr_a = 5; raddr_b = 17;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    n_cmp++; if (rdata_a !== '0) begin n_err++; $display("FAIL reset_rdata_a got=%h exp=0", rdata_a); end
    n_cmp++; if (rdata_b !== '0) begin n_err++; $display("FAIL reset_rdata_b got=%h exp=0", rdata_b); end
    n_cmp++; if (dbg_data !== '0) begin n_err++; $display("FAIL reset_dbg got=%h exp=0", dbg_data); end
    n_cmp++; if (busy_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
    n_cmp++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", iss_stall); end
    $display("reset release: rdata_a=%h rdata_b=%h dbg=%h cnt=%0d", rdata_a, rdata_b, dbg_data, busy_cnt);
    @(negedge clk);
  endtask

  task automatic test_write_read();
    we = 1; waddr = 3; wdata = 32'hDEADBEEF; raddr_a = 3;
    #1;
    n_cmp++; if (rdata_a !== model_rdata(3)) begin n_err++; $display("FAIL wr_pre_edge got=%h exp=%h", rdata_a, model_rdata(3)); end
    tick(); idle();
    #1;
    n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_read_a got=%h exp=deadbeef", rdata_a); end
    $display("write r3: rdata_a=%h", rdata_a);
    we = 1; waddr = 0; wdata = 32'h12345678; raddr_b = 0;
    #1;
    n_cmp++; if (rdata_b !== '0) begin n_err++; $display("FAIL r0_pre got=%h exp=0", rdata_b); end
    tick(); idle();
    #1;
    n_cmp++; if (rdata_b !== '0) begin n_err++; $display("FAIL r0_read got=%h exp=0", rdata_b); end
    $display("write r0: rdata_b=%h", rdata_b);
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_addr = 8;
    tick(); idle(); raddr_a = 8;
    #1;
    n_cmp++; if (rbusy_a !== 1'b1) begin n_err++; $display("FAIL sb_busy_set got=%b exp=1", rbusy_a); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_cnt_set got=%0d exp=1", busy_cnt); end
    we = 1; waddr = 8; wdata = 32'h0000_0808;
    tick(); idle();
    #1;
    n_cmp++; if (rbusy_a !== 1'b0) begin n_err++; $display("FAIL sb_busy_clr got=%b exp=0", rbusy_a); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL sb_cnt_clr got=%0d exp=0", busy_cnt); end
    $display("scoreboard r8: rbusy_a=%b cnt=%0d", rbusy_a, busy_cnt);
  endtask

  task automatic test_waw_stall();
    iss_valid = 1; iss_addr = 9;
    tick();
    raddr_a = 9; we = 0;
    #1;
    n_cmp++; if (iss_stall !== 1'b1) begin n_err++; $display("FAIL waw_stall got=%b exp=1", iss_stall); end
    tick();
    #1;
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL waw_cnt_hold got=%0d exp=1", busy_cnt); end
    we = 1; waddr = 9; wdata = 32'h9999_0009;
    #1;
    n_cmp++; if (iss_stall !== 1'b0) begin n_err++; $display("FAIL waw_release got=%b exp=0", iss_stall); end
    tick(); idle();
    #1;
    n_cmp++; if (rbusy_a !== 1'b1) begin n_err++; $display("FAIL waw_still_busy got=%b exp=1", rbusy_a); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL waw_cnt got=%0d exp=1", busy_cnt); end
    $display("waw r9: rbusy_a=%b cnt=%0d", rbusy_a, busy_cnt);
    we = 1; waddr = 9; wdata = 32'h9;
    tick(); idle();
  endtask

  task automatic test_diff_addr();
    iss_valid = 1; iss_addr = 4;
    tick();
    iss_addr = 6; we = 1; waddr = 4; wdata = 32'h4444;
    tick(); idle(); raddr_a = 4; raddr_b = 6;
    #1;
    n_cmp++; if (rbusy_a !== 1'b0) begin n_err++; $display("FAIL diff_r4 got=%b exp=0", rbusy_a); end
    n_cmp++; if (rbusy_b !== 1'b1) begin n_err++; $display("FAIL diff_r6 got=%b exp=1", rbusy_b); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL diff_cnt got=%0d exp=1", busy_cnt); end
    $display("set6/clr4: rbusy4=%b rbusy6=%b cnt=%0d", rbusy_a, rbusy_b, busy_cnt);
    we = 1; waddr = 6; wdata = 32'h6666;
    tick(); idle();
  endtask

  task automatic test_bypass();
    we = 1; waddr = 17; wdata = 32'h1;
    tick();
    wdata = 32'hA5A5A5A5; raddr_a = 17;
    #1;
    n_cmp++; if (rdata_a !== (BYPASS ? 32'hA5A5A5A5 : 32'h1)) begin n_err++; $display("FAIL bypass_rdata got=%h exp=%h", rdata_a, BYPASS ? 32'hA5A5A5A5 : 32'h1); end
    n_cmp++; if (dbg_data !== 32'h1) begin n_err++; $display("FAIL bypass_dbg_pre got=%h exp=1", dbg_data); end
    $display("bypass=%0d pre-edge: rdata_a=%h dbg=%h", BYPASS, rdata_a, dbg_data);
    tick(); idle();
    #1;
    n_cmp++; if (dbg_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_dbg_post got=%h exp=a5a5a5a5", dbg_data); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 400; n++) begin
      we        = ($urandom_range(0, 2) == 0);
      waddr     = AW'($urandom_range(0, 7));
      wdata     = $urandom;
      iss_valid = ($urandom_range(0, 1) == 0);
      iss_addr  = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      raddr_a   = AW'($urandom_range(0, 7));
      raddr_b   = ($urandom_range(0, 3) == 0) ? AW'(DBG) : AW'($urandom_range(0, 7));
      if (n % 50 == 0) begin
        we = 1; waddr = AW'(DBG);
      end
      #1;
      n_cmp++; if (iss_stall !== model_stall()) begin n_err++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, iss_stall, model_stall()); end
      a = raddr_a;
      n_cmp++; if (rdata_a !== model_rdata(a)) begin n_err++; $display("FAIL rnd_rdata_a n=%0d got=%h exp=%h", n, rdata_a, model_rdata(a)); end
      n_cmp++; if (rbusy_a !== model_rbusy(a)) begin n_err++; $display("FAIL rnd_rbusy_a n=%0d got=%b exp=%b", n, rbusy_a, model_rbusy(a)); end
      a = raddr_b;
      n_cmp++; if (rdata_b !== model_rdata(a)) begin n_err++; $display("FAIL rnd_rdata_b n=%0d got=%h exp=%h", n, rdata_b, model_rdata(a)); end
      n_cmp++; if (rbusy_b !== model_rbusy(a)) begin n_err++; $display("FAIL rnd_rbusy_b n=%0d got=%b exp=%b", n, rbusy_b, model_rbusy(a)); end
      n_cmp++; if (dbg_data !== m_regs[DBG]) begin n_err++; $display("FAIL rnd_dbg n=%0d got=%h exp=%h", n, dbg_data, m_regs[DBG]); end
      n_cmp++; if (int'(busy_cnt) !== model_cnt()) begin n_err++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, busy_cnt, model_cnt()); end
      $display("rnd %0d: we=%b wa=%0d iv=%b ia=%0d stall=%b cnt=%0d", n, we, waddr, iss_valid, iss_addr, iss_stall, busy_cnt);
      tick();
    end
    idle();
    #1;
    n_cmp++; if (int'(busy_cnt) !== model_cnt()) begin n_err++; $display("FAIL rnd_cnt_end got=%0d exp=%0d", busy_cnt, model_cnt()); end
  endtask

  task automatic test_async_reset();
    idle();
    for (int r = 10; r <= 12; r++) begin
      we = 1; waddr = AW'(r); wdata = 32'h100 + r; iss_valid = 1; iss_addr = AW'(r);
      tick();
    end
    idle();
    // r10..r12 were written and issued in the same cycles, so they are busy
    we = 1; waddr = 10; wdata = 32'hAAAA; iss_valid = 1; iss_addr = 10;
    tick(); idle();
    raddr_a = 10; raddr_b = 11;
    #1;
    n_cmp++; if (int'(busy_cnt) !== model_cnt()) begin n_err++; $display("FAIL arst_pre_cnt got=%0d exp=%0d", busy_cnt, model_cnt()); end
    n_cmp++; if (rdata_a !== 32'hAAAA) begin n_err++; $display("FAIL arst_pre_rdata got=%h exp=aaaa", rdata_a); end
    #1 rst = 0;
    model_reset();
    #1;
    n_cmp++; if (busy_cnt !== '0) begin n_err++; $display("FAIL arst_cnt got=%0d exp=0", busy_cnt); end
    n_cmp++; if (rdata_a !== '0) begin n_err++; $display("FAIL arst_rdata_a got=%h exp=0", rdata_a); end
    n_cmp++; if (rdata_b !== '0) begin n_err++; $display("FAIL arst_rdata_b got=%h exp=0", rdata_b); end
    n_cmp++; if (rbusy_a !== 1'b0) begin n_err++; $display("FAIL arst_rbusy got=%b exp=0", rbusy_a); end
    n_cmp++; if (dbg_data !== '0) begin n_err++; $display("FAIL arst_dbg got=%h exp=0", dbg_data); end
    $display("async reset: cnt=%0d rdata_a=%h rdata_b=%h", busy_cnt, rdata_a, rdata_b);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 0; raddr_a = '0; raddr_b = '0;
    idle();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_waw_stall();
    test_diff_addr();
    test_bypass();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
